// File: rtl/md_cell_pkg.sv
// Shared constants and FSM state encoding for the position-cell streamer.
// Optional count clamping is enabled with CELL_STREAM_CNT_CHECK_EN (see cell_particle_streamer).
package md_cell_pkg;

  localparam int POS_WIDTH        = 32;
  localparam int DEF_DATA_WIDTH   = 3 * POS_WIDTH;
  localparam int DEF_PARTICLE_NUM = 220;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int RAM_RD_LATENCY   = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CNT_RD   = 3'd1,
    CNT_WAIT = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } stream_state_e;

endpackage

// File: rtl/cell_stream_fifo.sv
// First-word-fall-through FIFO holding {pid, last, pos} beats; head is read straight from storage.
// Simultaneous push and pop while full is legal and leaves the occupancy unchanged.
module cell_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 105,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Qualify requests so a stray push into a full FIFO or pop from an empty one is dropped.
  always_comb begin
    do_pop_s  = pop && (count != {CNT_W{1'b0}});
    do_push_s = push && ((count != CNT_W'(DEPTH)) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count    <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/cell_particle_streamer.sv
// Reads one position-cell RAM (count at address 0, records at 1..N) and streams records as valid/ready beats.
// Define CELL_STREAM_CNT_CHECK_EN to clamp oversize counts to PARTICLE_NUM-1 and expose a sticky cnt_err.
module cell_particle_streamer
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cell_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
`ifdef CELL_STREAM_CNT_CHECK_EN
  ,
  output logic                  cnt_err
`endif
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 4) + 1;
  localparam int ENTRY_W = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [1:0]            LAT_LAST  = 2'(RAM_RD_LATENCY - 1);

  if (FIFO_DEPTH < 3 || PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_bad_params
    $error("cell_particle_streamer: FIFO_DEPTH must be >= 3 and PARTICLE_NUM must fit ADDR_WIDTH");
  end

  stream_state_e          state_r;
  logic [1:0]             wait_cnt_r;
  logic                   data_rd_r;
  logic                   s1_vld_r;
  logic                   s2_vld_r;
  logic [ADDR_WIDTH-1:0]  s1_pid_r;
  logic [ADDR_WIDTH-1:0]  s2_pid_r;
  logic [CNT_W-1:0]       fifo_count_s;
  logic                   fifo_empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic [ENTRY_W-1:0]     push_data_s;
  logic [ENTRY_W-1:0]     head_s;
  logic [OCC_W-1:0]       occupancy_s;
  logic                   credit_ok_s;
  logic                   drained_s;
  logic [ADDR_WIDTH-1:0]  next_addr_s;
  logic [ADDR_WIDTH-1:0]  count_s;
`ifdef CELL_STREAM_CNT_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  logic                   over_s;
`endif

  // Count word decode, clamped to the memory depth when checking is enabled.
  always_comb begin
`ifdef CELL_STREAM_CNT_CHECK_EN
    if (mem_q[ADDR_WIDTH-1:0] > MAX_CNT) begin
      count_s = MAX_CNT;
      over_s  = 1'b1;
    end else begin
      count_s = mem_q[ADDR_WIDTH-1:0];
      over_s  = 1'b0;
    end
`else
    count_s = mem_q[ADDR_WIDTH-1:0];
`endif
  end

  // Credit and drain decisions are made for the cycle after this edge, so this cycle's pop already counts.
  always_comb begin
    pop_s       = out_valid && out_ready;
    push_s      = s2_vld_r;
    push_data_s = {s2_pid_r, (s2_pid_r == cell_count), mem_q};
    next_addr_s = mem_address + ADDR_ONE;
    occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(data_rd_r) + OCC_W'(s1_vld_r) + OCC_W'(s2_vld_r);
    credit_ok_s = (occupancy_s - OCC_W'(pop_s)) < OCC_W'(FIFO_DEPTH);
    if (data_rd_r || s1_vld_r || s2_vld_r) begin
      drained_s = 1'b0;
    end else begin
      drained_s = (fifo_count_s == {CNT_W{1'b0}}) ||
                  ((fifo_count_s == CNT_W'(1)) && pop_s);
    end
  end

  // Control FSM with registered RAM-side and status outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cell_count  <= ADDR_ZERO;
      mem_address <= ADDR_ZERO;
      mem_rden    <= 1'b0;
      data_rd_r   <= 1'b0;
`ifdef CELL_STREAM_CNT_CHECK_EN
      cnt_err     <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      mem_rden  <= 1'b0;
      data_rd_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= CNT_RD;
            busy        <= 1'b1;
            mem_rden    <= 1'b1;
            mem_address <= ADDR_ZERO;
`ifdef CELL_STREAM_CNT_CHECK_EN
            cnt_err     <= 1'b0;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        CNT_RD: begin
          state_r    <= CNT_WAIT;
          wait_cnt_r <= 2'd0;
        end
        CNT_WAIT: begin
          if (wait_cnt_r != LAT_LAST) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end else begin
            cell_count <= count_s;
`ifdef CELL_STREAM_CNT_CHECK_EN
            cnt_err    <= over_s;
`endif
            if (count_s == ADDR_ZERO) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              mem_rden    <= 1'b1;
              data_rd_r   <= 1'b1;
              mem_address <= ADDR_ONE;
              state_r     <= (count_s == ADDR_ONE) ? DRAIN : STREAM;
            end
          end
        end
        STREAM: begin
          if (credit_ok_s) begin
            mem_rden    <= 1'b1;
            data_rd_r   <= 1'b1;
            mem_address <= next_addr_s;
            if (next_addr_s == cell_count) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained_s) begin
            state_r <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage in-flight tracker aligning each pid with its RAM data.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
      s1_pid_r <= ADDR_ZERO;
      s2_pid_r <= ADDR_ZERO;
    end else begin
      s1_vld_r <= data_rd_r;
      s1_pid_r <= mem_address;
      s2_vld_r <= s1_vld_r;
      s2_pid_r <= s1_pid_r;
    end
  end

  cell_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_pid   = head_s[ENTRY_W-1 -: ADDR_WIDTH];
  assign out_last  = head_s[DATA_WIDTH];
  assign out_pos   = head_s[DATA_WIDTH-1:0];
  assign mem_wren  = 1'b0;
  assign mem_data  = {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_cell_particle_streamer.sv
// Self-checking bench for cell_particle_streamer: RAM model, expected-beat queue and credit bookkeeping.
// Build with CELL_STREAM_CNT_CHECK_EN defined to also exercise count clamping.
module tb_cell_particle_streamer;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] cell_count;
  logic [AW-1:0] mem_address;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pos;
  logic [AW-1:0] out_pid;
  logic          out_last;
`ifdef CELL_STREAM_CNT_CHECK_EN
  logic          cnt_err;
`endif

  cell_particle_streamer dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .cell_count  (cell_count),
    .mem_address (mem_address),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_data    (mem_data),
    .mem_q       (mem_q),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pos     (out_pos),
    .out_pid     (out_pid),
    .out_last    (out_last)
`ifdef CELL_STREAM_CNT_CHECK_EN
    ,
    .cnt_err     (cnt_err)
`endif
  );

  always #5 clock = ~clock;

  // RAM with two cycles of read latency
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_p1;
  always @(posedge clock) begin
    if (mem_rden) ram_p1 <= ram[mem_address];
    mem_q <= ram_p1;
  end

  int total_checks = 0;
  int passed_checks = 0;
  int exp_q[$];
  int cell_n, issued, popped, done_cnt, cyc, first_valid_step, done_step, ready_mode;
  bit mon_en = 1'b0;
  bit hold_v = 1'b0;
  logic [DW+AW:0] hold_beat;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int exp_count(input int raw);
`ifdef CELL_STREAM_CNT_CHECK_EN
    return (raw > PN - 1) ? PN - 1 : raw;
`else
    return raw;
`endif
  endfunction

  // One clock cycle: choose out_ready, then observe the DUT at the falling edge.
  task automatic step();
    int p;
    @(negedge clock);
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat[cyc % 4];
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (mon_en) begin
      if (hold_v) begin
        check("stall_valid", 128'(out_valid), 128'(1));
        check("stall_beat", 128'({out_pid, out_last, out_pos}), 128'(hold_beat));
      end
      if (mem_rden && mem_address != 8'd0) begin
        check("credit", 128'((issued - popped) < 4), 128'(1));
        check("addr_range", 128'(int'(mem_address) <= cell_n), 128'(1));
        issued++;
      end
      check("mem_wren", 128'({mem_wren, mem_data}), 128'(0));
      if (done) begin
        done_cnt++;
        if (done_step < 0) done_step = cyc;
      end
      if (out_valid && first_valid_step < 0) first_valid_step = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat_pid", 128'(out_pid), 128'(0));
        end else begin
          p = exp_q.pop_front();
          check("beat_pid", 128'(out_pid), 128'(p));
          check("beat_pos", 128'(out_pos), 128'(ram[p]));
          check("beat_last", 128'(out_last), 128'(p == cell_n));
        end
        popped++;
      end
      hold_v = out_valid && !out_ready;
      hold_beat = {out_pid, out_last, out_pos};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 128'({busy, done, mem_rden, mem_wren, out_valid, out_last}), 128'(0));
    check({tag, "_addr"}, 128'({cell_count, mem_address, out_pid}), 128'(0));
    check({tag, "_data"}, 128'({mem_data, out_pos}), 128'(0));
`ifdef CELL_STREAM_CNT_CHECK_EN
    check({tag, "_cnt_err"}, 128'(cnt_err), 128'(0));
`endif
  endtask

  task automatic begin_cell(input int raw, input int mode);
    ram[0] = DW'(raw);
    for (int i = 1; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom};
    cell_n = exp_count(raw);
    exp_q.delete();
    for (int p = 1; p <= cell_n; p++) exp_q.push_back(p);
    issued = 0; popped = 0; done_cnt = 0; hold_v = 1'b0;
    first_valid_step = -1; done_step = -1; ready_mode = mode;
    mon_en = 1'b1;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic finish_cell(input int limit);
    for (int i = 0; i < limit && done_step < 0; i++) step();
    check("done_seen", 128'(done_step >= 0), 128'(1));
    step();
    step();
    check("beats_left", 128'(exp_q.size()), 128'(0));
    check("done_count", 128'(done_cnt), 128'(1));
    check("cell_count", 128'(cell_count), 128'(cell_n));
    check("busy_idle", 128'(busy), 128'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; ready_mode = 0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Three records with a ready consumer: fixed latency
    begin_cell(3, 0);
    finish_cell(40);
    check("first_valid_step", 128'(first_valid_step), 128'(7));
    check("done_step", 128'(done_step), 128'(10));

    // Empty cell
    begin_cell(0, 0);
    finish_cell(20);
    check("empty_done_step", 128'(done_step), 128'(4));
    check("empty_no_valid", 128'(first_valid_step), 128'(-1));

    // Single record
    begin_cell(1, 2);
    finish_cell(60);

    // Ten records under 1-0-0-1 backpressure
    begin_cell(10, 1);
    finish_cell(200);

    // Start re-pulsed mid-stream must be ignored
    begin_cell(10, 2);
    repeat (8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    finish_cell(300);

    // Reset after pid 4 has been taken
    begin_cell(10, 0);
    for (int i = 0; i < 40 && popped < 4; i++) step();
    check("popped_before_reset", 128'(popped), 128'(4));
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    mon_en = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("no_done_after_reset", 128'({done, busy, out_valid}), 128'(0));
    end
    begin_cell(10, 2);
    finish_cell(300);

    // Random cells under random backpressure
    repeat (3) begin
      n = $urandom_range(2, 60);
      begin_cell(n, 2);
      finish_cell(n * 20 + 60);
    end
    begin_cell(PN - 1, 0);
    finish_cell(PN * 4);

`ifdef CELL_STREAM_CNT_CHECK_EN
    // Oversize count is clamped
    begin_cell(250, 2);
    finish_cell(PN * 20);
    check("clamp_cnt_err", 128'(cnt_err), 128'(1));
`endif

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach the summary, checks %0d/%0d", passed_checks, total_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cell_particle_streamer.md
Name: cell_particle_streamer

Overview:
Downstream reader for one position-cell memory (single-port RAM, 2-cycle read latency; address 0 holds the particle count, addresses 1..N hold {posz,posy,posx}). On a start pulse it reads the count, then streams every particle record as a valid/ready beat with its particle id. A small internal FIFO absorbs read latency under backpressure. Feeds the force-evaluation pair filter and motion-update stages.

Parameters:
DATA_WIDTH, 96, record width {posz,posy,posx}, 32 bits each
PARTICLE_NUM, 220, memory depth in words, including the count word
ADDR_WIDTH, 8, memory address width
FIFO_DEPTH, 4, output buffer entries; must be >= 3

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a cell read-out
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last beat is accepted, or after count==0 is detected
cell_count  out  ADDR_WIDTH  count latched from address 0; holds until the next start
mem_address  out  ADDR_WIDTH  RAM address
mem_rden  out  1  RAM read enable
mem_wren  out  1  constant 0
mem_data  out  DATA_WIDTH  constant 0
mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the address/rden cycle
out_valid  out  1  beat valid
out_ready  in  1  consumer ready
out_pos  out  DATA_WIDTH  particle record
out_pid  out  ADDR_WIDTH  particle address, 1..N
out_last  out  1  high on the beat where out_pid==N

Behaviour:
- Reset: all outputs 0. FSM returns to IDLE. FIFO is flushed. In-flight tracker is cleared. Reset mid-stream abandons the cell with no done pulse.
- FSM states:
  - IDLE: start -> CNT_RD.
  - CNT_RD: 1 cycle, mem_address=0, mem_rden=1 -> CNT_WAIT.
  - CNT_WAIT: 2 cycles, then latch cell_count=mem_q[ADDR_WIDTH-1:0]. If the count is 0 -> DONE. Otherwise -> STREAM.
  - STREAM: issue reads for addr 1..N. When addr N has been issued -> DRAIN.
  - DRAIN: wait until in-flight==0 and FIFO is empty -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- start is ignored in any state other than IDLE.
- Read issue rule: issue a read only when (fifo_count + inflight) < FIFO_DEPTH. In-flight reads are tracked by a 2-stage shift register carrying {valid, pid}. When stage 2 is valid, mem_q is written into the FIFO with that pid.
- mem_rden=1 only in cycles that issue a read. mem_address holds its last value otherwise.
- FIFO is first-word-fall-through. out_valid = !empty. A beat transfers when out_valid && out_ready.
- out_pos, out_pid and out_last must stay stable while out_valid && !out_ready.
- Latency: start accepted at edge T0. Count read issued in cycle T1, latched at T3. First data read issued in cycle T4; first out_valid in cycle T6. With out_ready held high, throughput is 1 beat/cycle thereafter. done asserts in the cycle after the last beat transfers.
- busy=1 in every state except IDLE.
- Boundaries:
  - count==N==1: a single beat with out_last=1.
  - FIFO full while reads are in flight: cannot overflow, by the credit rule.
  - Simultaneous FIFO push and pop while full: legal; occupancy is unchanged.
  - Address increment never exceeds N.

Optional Feature:
CELL_STREAM_CNT_CHECK_EN
- Defined: if the latched count > PARTICLE_NUM-1, it is clamped to PARTICLE_NUM-1. The extra output port cnt_err (1 bit) goes high and is sticky until the next start. cell_count reports the clamped value.
- Undefined: the count is used raw, with no cnt_err port. Behaviour is undefined when the count exceeds the memory depth.

Decomposition:
- Package md_cell_pkg holds:
  - POS_WIDTH=32;
  - default DATA_WIDTH/ADDR_WIDTH/PARTICLE_NUM constants;
  - the streamer state enum (IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE);
  - RAM_RD_LATENCY=2.
- Sub-module cell_stream_fifo: synchronous FWFT FIFO of {pid, last, pos}, depth FIFO_DEPTH, with count output. It is instantiated once; the FSM, credit counter and latency shift register stay in the top.

Test Plan:
- RAM count=3, records 0x...01/02/03, out_ready=1, start at T0 -> beats pid 1,2,3 at T6,T7,T8; out_last on pid 3; done at T9; cell_count=3.
- Count=0, start -> no out_valid; done 4 cycles after start; busy low after done.
- Count=10, out_ready toggling 1-0-0-1 repeatedly -> all 10 records in order, none duplicated; out_* stable while stalled; mem_rden never issued while fifo_count+inflight=4.
- start re-pulsed during STREAM -> ignored; the stream completes normally with a single done.
- rst_n asserted mid-stream (after pid 4 of 10) -> all outputs 0 immediately. A new start then streams pid 1..10 correctly.
- With CELL_STREAM_CNT_CHECK_EN: count=250, PARTICLE_NUM=220 -> cell_count=219, cnt_err=1, 219 beats, last pid 219.
